// File: rtl/mul2x2_accum.sv
// Frame accumulator behind the 2x2 multiplier: sums FRAME products,
// then holds the frame sum on a valid/ready output until it is taken.
module mul2x2_accum #(
    parameter int ACC_W    = 12,
    parameter int FRAME    = 16,
    parameter int SATURATE = 1,
    localparam int CW      = $clog2(FRAME + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       M,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] ACC,
    output logic [CW-1:0]    COUNT,
    output logic             OVF
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    localparam logic [CW-1:0] FRAME_C = CW'(FRAME);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [ACC_W:0]   sum;
    logic [CW-1:0]    count_inc;

    assign accept    = IN_VALID && (state_q != S_HOLD);
    assign sum       = {1'b0, acc_q} + (ACC_W + 1)'(M);
    assign count_inc = count_q + CW'(1);

    // Next-state: CLR aborts like reset, otherwise step the frame FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (CLR) begin
            state_d = S_IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        acc_d   = ACC_W'(M);
                        count_d = CW'(1);
                        ovf_d   = 1'b0;
                        state_d = (FRAME == 1) ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        count_d = count_inc;
                        if (sum[ACC_W]) begin
                            ovf_d = 1'b1;
                            acc_d = (SATURATE != 0) ? '1 : sum[ACC_W-1:0];
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
                        if (count_inc == FRAME_C) begin
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (OUT_READY) begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign IN_READY  = (state_q != S_HOLD);
    assign OUT_VALID = (state_q == S_HOLD);
    assign ACC       = acc_q;
    assign COUNT     = count_q;
    assign OVF       = ovf_q;

endmodule
